// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the IF-stage fetch sequencer.
// FSM state encoding, default NOP and the PC increment helper.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [XLEN-1:0] pcPlus4(
    input logic [XLEN-1:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry {instr,pc} skid buffer used when
// decode is stalled as a response arrives. Clear beats push/pop.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] pushInstr,
  input  logic [XLEN-1:0] pushPc,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Entry register: a push refills even when popped the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= pushInstr;
      pc    <= pushPc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage sequencer, one outstanding imem request.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_dropped counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  import fetch_pkg::ISSUE;
  import fetch_pkg::WAIT;
  import fetch_pkg::DROP;
  import fetch_pkg::pcPlus4;

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [31:0] pcF;
  logic [31:0] pendPc;

  logic        grant;
  logic        respKeep;
  logic        respDrop;
  logic        ifidFree;
  logic        loadHold;
  logic        loadResp;
  logic        pushHold;

  logic        holdFull;
  logic [31:0] holdInstr;
  logic [31:0] holdPc;

  assign imem_addr = pcF;
  assign grant     = imem_req && imem_gnt;
  assign ifidFree  = !ValidD || !StallD;

  assign respKeep  = (state == WAIT) && imem_rvalid && !PCSrcE;
  assign respDrop  = imem_rvalid &&
                     ((state == DROP) ||
                      ((state == WAIT) && PCSrcE));

  assign loadHold  = holdFull && ifidFree && !PCSrcE;
  assign loadResp  = respKeep && ifidFree && !holdFull;
  assign pushHold  = respKeep && !loadResp;

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .push      (pushHold),
    .pop       (loadHold),
    .clear     (PCSrcE),
    .pushInstr (imem_rdata),
    .pushPc    (pendPc),
    .full      (holdFull),
    .instr     (holdInstr),
    .pc        (holdPc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ISSUE;
    else     state <= stateNext;
  end

  // Next state: a redirect with a request in flight must drop its response.
  always_comb begin
    stateNext = state;
    unique case (state)
      ISSUE: begin
        if (grant) stateNext = PCSrcE ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) stateNext = ISSUE;
        else if (PCSrcE) stateNext = DROP;
      end
      DROP: begin
        if (imem_rvalid) stateNext = ISSUE;
      end
      default: stateNext = ISSUE;
    endcase
  end

  // Request only when idle and there is room to park the answer.
  always_comb begin
    imem_req = 1'b0;
    if (!rst && (state == ISSUE) && !holdFull) imem_req = 1'b1;
  end

  // Fetch PC and the address of the request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF    <= RESET_PC;
      pendPc <= RESET_PC;
    end else begin
      if (PCSrcE)        pcF <= PCTargetE;
      else if (respKeep) pcF <= pcPlus4(pendPc);
      if (grant)         pendPc <= pcF;
    end
  end

  // IF/ID register: redirect, then hold, then response, then consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (PCSrcE) begin
      ValidD <= 1'b0;
      InstrD <= NOP_INSTR;
    end else if (loadHold) begin
      ValidD   <= 1'b1;
      InstrD   <= holdInstr;
      PCD      <= holdPc;
      PCPlus4D <= pcPlus4(holdPc);
    end else if (loadResp) begin
      ValidD   <= 1'b1;
      InstrD   <= imem_rdata;
      PCD      <= pendPc;
      PCPlus4D <= pcPlus4(pendPc);
    end else if (ValidD && !StallD) begin
      ValidD <= 1'b0;
      InstrD <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count delivered and discarded responses, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (respKeep) perf_fetched <= perf_fetched + 32'd1;
      if (respDrop) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, wrap/reset sequence on a
// second instance, then randomized traffic against a queue model.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D1  = 32'h0050_0093;
  localparam logic [31:0] D2  = 32'h00A0_0113;
  localparam logic [31:0] D3  = 32'h0010_0193;
  localparam logic [31:0] D4  = 32'h0020_0213;
  localparam logic [31:0] D5  = 32'hDEAD_BEEF;
  localparam logic [31:0] D6  = 32'h0030_0293;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, PCSrcE, StallD, imem_gnt, imem_rvalid;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;

  logic        rst1, red1, stall1, gnt1, rv1;
  logic [31:0] tgt1, rd1;
  logic        req1, vld1;
  logic [31:0] addr1, instr1, pcd1, p41;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped;
  logic [31:0] perf_fetched1, perf_dropped1;
`endif

  fetch_sequencer u0 (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst1), .PCSrcE(red1), .PCTargetE(tgt1),
    .StallD(stall1), .imem_req(req1), .imem_addr(addr1),
    .imem_gnt(gnt1), .imem_rvalid(rv1), .imem_rdata(rd1),
    .InstrD(instr1), .PCD(pcd1), .PCPlus4D(p41), .ValidD(vld1)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched1), .perf_dropped(perf_dropped1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [129:0] act,
                     input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, red;
    logic [31:0] tgt;
    logic        stall, gnt, rv;
    logic [31:0] rdata;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eVld;
    logic [31:0] eInstr, ePcd, eP4;
  } vec_t;

  function automatic vec_t mk(
    logic r, logic rd, logic [31:0] t, logic s, logic g, logic v,
    logic [31:0] d, logic eq, logic [31:0] ea, logic ev,
    logic [31:0] ei, logic [31:0] ep, logic [31:0] e4);
    vec_t x;
    x.rst = r; x.red = rd; x.tgt = t; x.stall = s; x.gnt = g;
    x.rv = v; x.rdata = d; x.eReq = eq; x.eAddr = ea; x.eVld = ev;
    x.eInstr = ei; x.ePcd = ep; x.eP4 = e4;
    return x;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  vec_t tbl[27];

  ent_t        q[$];
  logic [31:0] mPc, mPcd, mP4, pcOld, tgt, rdata;
  bit          mOut, mStale, keep, resp, grant, eReq;
  bit          r, red, stall, gnt, rv, memBusy;
  int          cd;
  int unsigned mFet, mDrop;

  initial begin
    rst = 1; PCSrcE = 0; PCTargetE = 0; StallD = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    rst1 = 1; red1 = 0; tgt1 = 0; stall1 = 0;
    gnt1 = 0; rv1 = 0; rd1 = 0;

    //            rst red tgt     st g rv data | req addr  v instr pcd p4
    tbl[0]  = mk(1, 0, 0,      0, 0, 0, 0,  0, 0,      0, NOP, 0, 0);
    tbl[1]  = mk(0, 0, 0,      0, 1, 0, 0,  0, 0,      0, NOP, 0, 0);
    tbl[2]  = mk(0, 0, 0,      0, 0, 1, D1, 1, 4,      1, D1,  0, 4);
    tbl[3]  = mk(0, 0, 0,      0, 1, 0, 0,  0, 4,      0, NOP, 0, 4);
    tbl[4]  = mk(0, 0, 0,      0, 0, 1, D2, 1, 8,      1, D2,  4, 8);
    tbl[5]  = mk(0, 0, 0,      1, 0, 0, 0,  1, 8,      1, D2,  4, 8);
    tbl[6]  = mk(0, 0, 0,      1, 0, 0, 0,  1, 8,      1, D2,  4, 8);
    tbl[7]  = mk(0, 0, 0,      0, 0, 0, 0,  1, 8,      0, NOP, 4, 8);
    tbl[8]  = mk(0, 0, 0,      0, 1, 0, 0,  0, 8,      0, NOP, 4, 8);
    tbl[9]  = mk(0, 0, 0,      0, 0, 1, D3, 1, 12,     1, D3,  8, 12);
    tbl[10] = mk(0, 0, 0,      1, 1, 0, 0,  0, 12,     1, D3,  8, 12);
    tbl[11] = mk(0, 0, 0,      1, 0, 1, D4, 0, 16,     1, D3,  8, 12);
    tbl[12] = mk(0, 0, 0,      1, 1, 0, 0,  0, 16,     1, D3,  8, 12);
    tbl[13] = mk(0, 0, 0,      0, 0, 0, 0,  1, 16,     1, D4,  12, 16);
    tbl[14] = mk(0, 0, 0,      0, 0, 0, 0,  1, 16,     0, NOP, 12, 16);
    tbl[15] = mk(0, 0, 0,      0, 1, 0, 0,  0, 16,     0, NOP, 12, 16);
    tbl[16] = mk(0, 1, 'h40,   0, 0, 0, 0,  0, 'h40,   0, NOP, 12, 16);
    tbl[17] = mk(0, 0, 0,      0, 0, 1, D5, 1, 'h40,   0, NOP, 12, 16);
    tbl[18] = mk(0, 0, 0,      0, 1, 0, 0,  0, 'h40,   0, NOP, 12, 16);
    tbl[19] = mk(0, 1, 'h80,   0, 0, 1, D5, 1, 'h80,   0, NOP, 12, 16);
    tbl[20] = mk(0, 1, 'h100,  0, 1, 0, 0,  0, 'h100,  0, NOP, 12, 16);
    tbl[21] = mk(0, 0, 0,      0, 0, 1, D5, 1, 'h100,  0, NOP, 12, 16);
    tbl[22] = mk(0, 0, 0,      0, 1, 0, 0,  0, 'h100,  0, NOP, 12, 16);
    tbl[23] = mk(0, 0, 0,      0, 0, 1, D6, 1, 'h104,  1, D6, 'h100, 'h104);
    tbl[24] = mk(0, 0, 0,      0, 1, 0, 0,  0, 'h104,  0, NOP, 'h100, 'h104);
    tbl[25] = mk(1, 0, 0,      0, 0, 0, 0,  0, 0,      0, NOP, 0, 0);
    tbl[26] = mk(0, 0, 0,      0, 0, 0, 0,  1, 0,      0, NOP, 0, 0);

    for (int i = 0; i < 27; i++) begin
      rst = tbl[i].rst; PCSrcE = tbl[i].red; PCTargetE = tbl[i].tgt;
      StallD = tbl[i].stall; imem_gnt = tbl[i].gnt;
      imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i),
          {imem_req, imem_addr, ValidD, InstrD, PCD, PCPlus4D},
          {tbl[i].eReq, tbl[i].eAddr, tbl[i].eVld, tbl[i].eInstr,
           tbl[i].ePcd, tbl[i].eP4});
`ifdef FETCH_PERF_CNT_EN
      if (i == 24) begin
        chk("perf_fetched", {98'd0, perf_fetched}, {98'd0, 32'd5});
        chk("perf_dropped", {98'd0, perf_dropped}, {98'd0, 32'd3});
      end
`endif
    end

    // PC wrap at the top of the address space, then reset while waiting.
    rst1 = 1; @(posedge clk); #1;
    chk("wrap_rst", {req1, addr1}, {1'b0, 32'hFFFF_FFFC});
    rst1 = 0; gnt1 = 1; @(posedge clk); #1;
    chk("wrap_gnt", {req1, addr1, vld1}, {1'b0, 32'hFFFF_FFFC, 1'b0});
    gnt1 = 0; rv1 = 1; rd1 = D1; @(posedge clk); #1;
    chk("wrap_resp", {req1, addr1, vld1, instr1, pcd1, p41},
        {1'b1, 32'h0, 1'b1, D1, 32'hFFFF_FFFC, 32'h0});
    rv1 = 0; gnt1 = 1; @(posedge clk); #1;
    chk("wrap_next", {req1, addr1, vld1}, {1'b0, 32'h0, 1'b0});
    gnt1 = 0; rst1 = 1; @(posedge clk); #1;
    chk("wait_rst", {req1, addr1, vld1, instr1, pcd1, p41},
        {1'b0, 32'hFFFF_FFFC, 1'b0, NOP, 32'h0, 32'h0});
    rst1 = 0; @(posedge clk); #1;
    chk("wait_rst_issue", {req1, addr1}, {1'b1, 32'hFFFF_FFFC});

    // Randomized traffic against a model of the fetch stream.
    memBusy = 0; cd = 0;
    mOut = 0; mStale = 0; mPc = 0; mPcd = 0; mP4 = 0;
    mFet = 0; mDrop = 0;
    for (int c = 0; c < 4000; c++) begin
      r     = (c < 2) || ($urandom_range(499) == 0);
      red   = ($urandom_range(9) == 0);
      tgt   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC
                                       : ($urandom & 32'hFFFF_FFFC);
      stall = ($urandom_range(2) == 0);
      gnt   = $urandom_range(1) == 1;
      rv    = memBusy && (cd == 0);
      rdata = $urandom;
      rst = r; PCSrcE = red; PCTargetE = tgt; StallD = stall;
      imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rdata;

      eReq  = !r && !mOut && (q.size() < 2);
      grant = eReq && gnt;

      if (r) begin
        q.delete(); mOut = 0; mStale = 0; mPc = 0;
        mPcd = 0; mP4 = 0; mFet = 0; mDrop = 0;
      end else begin
        keep = 0; pcOld = mPc;
        resp = mOut && rv;
        if (resp) begin
          mOut = 0;
          keep = !mStale && !red;
          if (keep) mFet++;
          else mDrop++;
          mStale = 0;
        end
        if (grant) begin
          mOut = 1; mStale = 0;
        end
        if (red) begin
          mPc = tgt;
          if (mOut) mStale = 1;
          q.delete();
        end else begin
          if (q.size() > 0 && !stall) void'(q.pop_front());
          if (keep) begin
            q.push_back('{rdata, pcOld});
            mPc = pcOld + 32'd4;
          end
        end
        if (q.size() > 0) begin
          mPcd = q[0].pc; mP4 = q[0].pc + 32'd4;
        end
      end

      if (r) memBusy = 0;
      else begin
        if (rv) memBusy = 0;
        else if (memBusy && cd > 0) cd--;
        if (grant) begin
          memBusy = 1; cd = $urandom_range(3);
        end
      end

      @(posedge clk); #1;
      chk($sformatf("rand%0d", c),
          {imem_req, imem_addr, ValidD, InstrD, PCD, PCPlus4D},
          {(!r && !mOut && (q.size() < 2)), mPc, (q.size() > 0),
           ((q.size() > 0) ? q[0].instr : NOP), mPcd, mP4});
    end
`ifdef FETCH_PERF_CNT_EN
    chk("rand_fetched", {98'd0, perf_fetched}, {98'd0, 32'(mFet)});
    chk("rand_dropped", {98'd0, perf_dropped}, {98'd0, 32'(mDrop)});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
